atari_cart_bus_reader: RTL and testbench
========================================

Name: atari_cart_bus_reader

Overview:
- Atari-side requester for the external SRAM bridge: serves Atari 8-bit cartridge bus reads from SRAM.
- Synchronises PHI2, S4/S5/CCTL strobes into clk_clk and decodes window plus bank for the selected cartridge type.
- Drives the SRAM address and enable into the bridge, then returns the SRAM byte onto the cartridge data bus.
- Also handles CCTL bank-switch writes and RD4/RD5 signalling.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of input synchronisers (min 2).
- SRAM_WAIT, 3, clk_clk cycles from sram_enable rising to sram_data valid.
- ADDR_W, 20, SRAM address width.

Ports:
- clk_clk  in  1  system clock (>=8x PHI2).
- reset_reset_n  in  1  asynchronous active-low reset.
- cart_type  in  8  selected cartridge type: 0 off, 1 std 8K, 2 std 16K, 3 XEGS 32-1024K, 4 AtariMax 128K.
- phi2  in  1  Atari PHI2, asynchronous.
- rw  in  1  Atari R/W (1 = read).
- s4_n, s5_n, cctl_n  in  1 each  Atari window strobes, active low.
- a  in  13  Atari address A12..A0.
- d_in  in  8  Atari data bus, input side.
- d_out  out  8  data driven to the Atari.
- d_oe  out  1  data bus output enable.
- rd4, rd5  out  1 each  cartridge-present lines.
- sram_addr  out  ADDR_W  address to the SRAM bridge.
- sram_enable  out  1  read request to the SRAM bridge.
- sram_data  in  8  SRAM read byte.
- bus_driven  out  1  high while the Atari cycle owns SRAM.
- reset_d500  in  1  pulse that clears bank state.
- d500_byte  out  8  last CCTL write data (optional feature).

Behaviour:
- Reset values: d_out=0, d_oe=0, rd4=0, rd5=0, sram_addr=0, sram_enable=0, bus_driven=0, bank=0, d500_byte=0.
- Synchronisation: phi2, rw, s4_n, s5_n, cctl_n pass through SYNC_STAGES flops. phi2 rise/fall is detected on the synchronised copy. a and d_in are sampled only in DECODE, when they are stable.
- rd4 = (type 2 or type 3) and not disabled.
- rd5 = (type 1, 2, 3 or 4) and not disabled.
- Disable rule: type 4 with bank bit 7 set forces rd4=rd5=0.
- Address mapping:
  - type 1, S5: {7'b0, a}.
  - type 2: S4 -> {7'b0, 0, a}; S5 -> {7'b0, 1, a}.
  - type 3: S4 -> {bank[6:0], a}; S5 -> last bank {7'h7F, a}, with the bank masked to the cart size by the upper layer.
  - type 4, S5: {bank[3:0], a}.
  - All widths are truncated to ADDR_W.
- CCTL write, rw=0 with cctl_n low:
  - type 3: bank <= d_in.
  - type 4: bank <= {a[4], 3'b0, a[3:0]}. Access with data ignored, reads also switch.
  - Other types: ignored.
- State machine:
  - IDLE: wait for phi2 rising.
  - DECODE: one cycle. If an enabled window read hits -> FETCH, with sram_addr loaded, sram_enable=1, bus_driven=1. If CCTL -> CCTL_WR. Else -> IDLE.
  - FETCH: count SRAM_WAIT cycles, then latch sram_data into d_out -> DRIVE.
  - DRIVE: d_oe=1 until phi2 falling, then d_oe=0, sram_enable=0, bus_driven=0 -> IDLE.
  - CCTL_WR: wait for phi2 falling, apply the bank write on that edge -> IDLE.
- Early phi2 fall during FETCH: abort, d_oe stays 0, drop enable -> IDLE.
- reset_d500 high in any state: bank<=0 and d500_byte<=0 next cycle. A simultaneous CCTL write loses to reset_d500.
- cart_type=0: never drives, rd4=rd5=0. A cart_type change takes effect at the next DECODE.
- d_oe is never asserted when rw=0.

Optional Feature:
- ATARI_D500_CAPTURE_EN defined: every CCTL write, any type, latches d_in into d500_byte on phi2 falling; cleared by reset_d500.
- Undefined: d500_byte is tied to 0 and the capture flops are absent.

Decomposition:
- Package atari_cart_pkg holds:
  - cart type constants CART_OFF/STD8K/STD16K/XEGS/ATARIMAX;
  - the state enum;
  - window-size localparams.
- Sub-module atari_bus_sync: parameterised N-bit multi-stage synchroniser with edge detect.

Test Plan:
- Type 1: preload SRAM 0x00123=0x5A; S5 read a=0x0123 -> sram_addr=0x00123, d_out=0x5A with d_oe high until phi2 falls; rd5=1, rd4=0.
- Type 2: S4 read a=0x0010 -> sram_addr=0x00010; S5 read a=0x0010 -> sram_addr=0x02010.
- Type 3: CCTL write d=0x05, then S4 read a=0x0000 -> sram_addr=0x0A000; S5 read -> 0xFE000.
- Type 4: CCTL access a=0x13 (bank bit 7 set) -> rd5=0 and the next S5 read is not driven; access a=0x02 -> rd5=1, S5 a=0x0 -> sram_addr=0x04000.
- Reset corners:
  - reset_d500 coincident with a CCTL write -> bank=0.
  - reset_reset_n low mid-FETCH -> all outputs 0 immediately.
  - phi2 falls during FETCH -> d_oe never asserted.
- With ATARI_D500_CAPTURE_EN: CCTL write 0xA7 in type 1 -> d500_byte=0xA7; without the macro -> d500_byte stays 0.

Source files
------------

// File: rtl/atari_cart_pkg.sv
// atari_cart_pkg: shared definitions for the Atari cartridge bus reader.
//   - cartridge type codes (cart_type input encoding)
//   - controller state encoding
//   - cartridge window geometry (8K windows, 13 address bits)
//   - map_addr(): window address to flat SRAM address for one cart type
package atari_cart_pkg;

  localparam logic [7:0] CART_OFF      = 8'd0;
  localparam logic [7:0] CART_STD8K    = 8'd1;
  localparam logic [7:0] CART_STD16K   = 8'd2;
  localparam logic [7:0] CART_XEGS     = 8'd3;
  localparam logic [7:0] CART_ATARIMAX = 8'd4;

  // Each S4/S5 window is 8K, addressed by A12..A0.
  localparam int WIN_ADDR_W = 13;
  // Widest mapping is {7 bits, 1 bit, 13 bits}; callers truncate to ADDR_W.
  localparam int MAP_W      = 21;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DRIVE   = 3'd3,
    ST_CCTL_WR = 3'd4
  } state_t;

  // Only bank[6:0] ever reaches an address; bank[7] is the AtariMax disable.
  function automatic logic [MAP_W-1:0] map_addr(
    input logic [7:0]            ctype,
    input logic                  s5_sel,
    input logic [6:0]            bank_lo,
    input logic [WIN_ADDR_W-1:0] a
  );
    logic [MAP_W-1:0] r;
    r = '0;
    case (ctype)
      CART_STD8K:    r = {8'b0, a};
      CART_STD16K:   r = {7'b0, s5_sel, a};
      // XEGS: S5 is always the last bank; the upper layer masks to cart size.
      CART_XEGS:     r = s5_sel ? {1'b0, 7'h7F, a} : {1'b0, bank_lo, a};
      CART_ATARIMAX: r = {4'b0, bank_lo[3:0], a};
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/atari_bus_sync.sv
// atari_bus_sync: N-bit multi-stage synchroniser with rise/fall detect on
// the synchronised copy.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_async[N]     : asynchronous inputs
//   o_sync[N]      : synchronised inputs (STAGES flops deep, STAGES >= 2)
//   o_rise/o_fall  : one-cycle pulses on synchronised edges
module atari_bus_sync #(
  parameter int             N       = 1,
  parameter int             STAGES  = 2,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_async,
  output logic [N-1:0] o_sync,
  output logic [N-1:0] o_rise,
  output logic [N-1:0] o_fall
);

  logic [N-1:0] r_chain [STAGES];
  logic [N-1:0] r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_chain[i] <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_chain[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
      r_prev <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/atari_cart_bus_reader.sv
// atari_cart_bus_reader: Atari-side requester for the external SRAM bridge.
// Serves cartridge S4/S5 reads from SRAM, handles CCTL bank switching and
// drives RD4/RD5.
//   clk_clk, reset_reset_n   : system clock (>= 8x PHI2), async active-low reset
//   cart_type                : 0 off, 1 std 8K, 2 std 16K, 3 XEGS, 4 AtariMax
//   phi2, rw, s4_n, s5_n,
//   cctl_n, a, d_in          : Atari bus (asynchronous)
//   d_out, d_oe              : data returned to the Atari and its enable
//   rd4, rd5                 : cartridge-present lines
//   sram_addr, sram_enable,
//   sram_data, bus_driven    : SRAM bridge request/response
//   reset_d500               : clears bank state (wins over a CCTL write)
//   d500_byte                : last CCTL write data
// Optional build macro ATARI_D500_CAPTURE_EN: capture CCTL write data into
// d500_byte. Without it d500_byte is tied to 0.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for PHI2 rising
// DECODE     | one cycle: sample a/d_in/type, pick read, CCTL or nothing
// FETCH      | SRAM request outstanding, counting SRAM_WAIT
// DRIVE      | d_out valid, d_oe high until PHI2 falls
// CCTL_WR    | waiting for PHI2 falling to apply the bank write
module atari_cart_bus_reader
  import atari_cart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SRAM_WAIT   = 3,
  parameter int ADDR_W      = 20
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [7:0]            cart_type,
  input  logic                  phi2,
  input  logic                  rw,
  input  logic                  s4_n,
  input  logic                  s5_n,
  input  logic                  cctl_n,
  input  logic [WIN_ADDR_W-1:0] a,
  input  logic [7:0]            d_in,
  output logic [7:0]            d_out,
  output logic                  d_oe,
  output logic                  rd4,
  output logic                  rd5,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic                  sram_enable,
  input  logic [7:0]            sram_data,
  output logic                  bus_driven,
  input  logic                  reset_d500,
  output logic [7:0]            d500_byte
);

  localparam int WAIT_W = $clog2(SRAM_WAIT + 1);

  logic [4:0] w_sync, w_rise, w_fall;
  logic       w_phi2_rise, w_phi2_fall, w_rw, w_s4_n, w_s5_n, w_cctl_n;

  // Reset values present an idle bus: PHI2 low, read, strobes inactive.
  atari_bus_sync #(
    .N       (5),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (5'b11110)
  ) u_sync (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_async ({cctl_n, s5_n, s4_n, rw, phi2}),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_phi2_rise = w_rise[0];
  assign w_phi2_fall = w_fall[0];
  assign w_rw        = w_sync[1];
  assign w_s4_n      = w_sync[2];
  assign w_s5_n      = w_sync[3];
  assign w_cctl_n    = w_sync[4];

  logic w_unused;
  assign w_unused = ^{w_sync[0], w_rise[4:1], w_fall[4:1]};

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait;
  logic [7:0]          r_bank;
  logic [7:0]          r_type;
  logic [4:0]          r_a_lo;
  logic [7:0]          r_d;
  logic                r_rw;
  logic [7:0]          r_d_out;
  logic                r_d_oe;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic                r_sram_en;
  logic                r_bus_drv;

  // Decode uses the live cart_type so a type change takes effect here.
  logic             w_dis_now, w_s4_ok, w_s5_ok, w_hit_s4, w_hit_s5, w_hit;
  logic [MAP_W-1:0] w_map;

  assign w_dis_now = (cart_type == CART_ATARIMAX) && r_bank[7];
  assign w_s4_ok   = (cart_type == CART_STD16K) || (cart_type == CART_XEGS);
  assign w_s5_ok   = (cart_type != CART_OFF) && (cart_type <= CART_ATARIMAX) && !w_dis_now;
  assign w_hit_s4  = w_rw && !w_s4_n && w_s4_ok;
  assign w_hit_s5  = w_rw && !w_s5_n && w_s5_ok && !w_hit_s4;
  assign w_hit     = w_hit_s4 || w_hit_s5;
  assign w_map     = map_addr(cart_type, w_hit_s5, r_bank[6:0], a);

  // Present lines follow the type captured at the last DECODE.
  logic w_dis_q;
  assign w_dis_q = (r_type == CART_ATARIMAX) && r_bank[7];
  assign rd4 = ((r_type == CART_STD16K) || (r_type == CART_XEGS)) && !w_dis_q;
  assign rd5 = (r_type != CART_OFF) && (r_type <= CART_ATARIMAX) && !w_dis_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_type      <= CART_OFF;
      r_a_lo      <= '0;
      r_d         <= '0;
      r_rw        <= 1'b1;
      r_d_out     <= '0;
      r_d_oe      <= 1'b0;
      r_sram_addr <= '0;
      r_sram_en   <= 1'b0;
      r_bus_drv   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_phi2_rise) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_type <= cart_type;
          r_a_lo <= a[4:0];
          r_d    <= d_in;
          r_rw   <= w_rw;
          if (w_phi2_fall) begin
            r_state <= ST_IDLE;
          end else if (w_hit) begin
            r_sram_addr <= ADDR_W'(w_map);
            r_sram_en   <= 1'b1;
            r_bus_drv   <= 1'b1;
            r_wait      <= WAIT_W'(SRAM_WAIT);
            r_state     <= ST_FETCH;
          end else if (!w_cctl_n) begin
            r_state <= ST_CCTL_WR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          // The data is sampled one cycle after SRAM_WAIT has elapsed so it
          // is already settled at the sampling edge.
          if (w_phi2_fall) begin
            r_sram_en <= 1'b0;
            r_bus_drv <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (r_wait == '0) begin
            r_d_out <= sram_data;
            r_d_oe  <= 1'b1;
            r_state <= ST_DRIVE;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (w_phi2_fall) begin
            r_d_oe    <= 1'b0;
            r_sram_en <= 1'b0;
            r_bus_drv <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_CCTL_WR: begin
          if (w_phi2_fall) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic w_cctl_apply;
  assign w_cctl_apply = (r_state == ST_CCTL_WR) && w_phi2_fall;

  // AtariMax switches on any CCTL access, read or write, from the address.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_bank <= '0;
    end else if (reset_d500) begin
      r_bank <= '0;
    end else if (w_cctl_apply) begin
      if (r_type == CART_XEGS && !r_rw) r_bank <= r_d;
      else if (r_type == CART_ATARIMAX) r_bank <= {r_a_lo[4], 3'b000, r_a_lo[3:0]};
    end
  end

`ifdef ATARI_D500_CAPTURE_EN
  logic [7:0] r_d500;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_d500 <= '0;
    end else if (reset_d500) begin
      r_d500 <= '0;
    end else if (w_cctl_apply && !r_rw) begin
      r_d500 <= r_d;
    end
  end
  assign d500_byte = r_d500;
`else
  assign d500_byte = 8'h00;
`endif

  assign d_out       = r_d_out;
  assign d_oe        = r_d_oe;
  assign sram_addr   = r_sram_addr;
  assign sram_enable = r_sram_en;
  assign bus_driven  = r_bus_drv;

endmodule

// File: tb/tb_atari_cart_bus_reader.sv
module tb_atari_cart_bus_reader;
  localparam int SYNC_STAGES = 2;
  localparam int SRAM_WAIT   = 3;
  localparam int ADDR_W      = 20;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b0;
  logic [7:0]        cart_type = 8'd0;
  logic              phi2 = 1'b0;
  logic              rw = 1'b1;
  logic              s4_n = 1'b1, s5_n = 1'b1, cctl_n = 1'b1;
  logic [12:0]       a = '0;
  logic [7:0]        d_in = '0;
  logic [7:0]        d_out;
  logic              d_oe, rd4, rd5;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_enable;
  logic [7:0]        sram_data;
  logic              bus_driven;
  logic              reset_d500 = 1'b0;
  logic [7:0]        d500_byte;

  always #5 clk_clk = ~clk_clk;

  atari_cart_bus_reader #(
    .SYNC_STAGES(SYNC_STAGES), .SRAM_WAIT(SRAM_WAIT), .ADDR_W(ADDR_W)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .cart_type(cart_type),
    .phi2(phi2), .rw(rw), .s4_n(s4_n), .s5_n(s5_n), .cctl_n(cctl_n),
    .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .rd4(rd4), .rd5(rd5),
    .sram_addr(sram_addr), .sram_enable(sram_enable), .sram_data(sram_data),
    .bus_driven(bus_driven), .reset_d500(reset_d500), .d500_byte(d500_byte)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM contents: fixed pseudo-random bytes with the one preloaded location.
  function automatic logic [7:0] sram_model(input logic [ADDR_W-1:0] ad);
    logic [31:0] x;
    if (ad == 20'h00123) return 8'h5A;
    x = 32'(ad) * 32'h9E3779B1;
    x = x ^ (x >> 15);
    return x[23:16];
  endfunction

  // Bridge latency: returns junk until SRAM_WAIT cycles after enable rose.
  int sram_cnt = 0;
  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) sram_cnt <= 0;
    else                sram_cnt <= sram_enable ? sram_cnt + 1 : 0;
  end
  assign sram_data = (sram_cnt >= SRAM_WAIT) ? sram_model(sram_addr) : ~sram_model(sram_addr);

  // Reference model state
  logic [7:0]  m_bank = 8'd0;
  logic [7:0]  m_type = 8'd0;
  logic [7:0]  m_d500 = 8'd0;
  bit          exp_hit = 1'b0, exp_drive = 1'b0;
  logic [19:0] exp_addr = '0;
  bit          cmp_en = 1'b0, quiet = 1'b0;
  logic [31:0] seen_addr, seen_dout;
  int          n_oe, n_bd;

  function automatic bit model_rd4();
    return (m_type == 8'd2) || (m_type == 8'd3);
  endfunction

  function automatic bit model_rd5();
    return (m_type >= 8'd1) && (m_type <= 8'd4) && !((m_type == 8'd4) && m_bank[7]);
  endfunction

  always @(negedge clk_clk) begin
    if (cmp_en) begin
      if (bus_driven || sram_enable) begin
        n_bd++;
        seen_addr = 32'(sram_addr);
        check("bus_driven", 32'(bus_driven), 32'(exp_hit));
        check("sram_enable", 32'(sram_enable), 32'(exp_hit));
        check("sram_addr", 32'(sram_addr), 32'(exp_addr));
      end
      if (d_oe) begin
        n_oe++;
        seen_dout = 32'(d_out);
        check("d_oe_allowed", 32'(d_oe), 32'(exp_drive));
        check("d_out", 32'(d_out), 32'(sram_model(exp_addr)));
      end
      if (quiet) begin
        check("rd4", 32'(rd4), 32'(model_rd4()));
        check("rd5", 32'(rd5), 32'(model_rd5()));
        check("d500_byte", 32'(d500_byte), 32'(m_d500));
        check("idle_d_oe", 32'(d_oe), 0);
        check("idle_bus_driven", 32'(bus_driven), 0);
      end
    end
  end

  // win: 0 none, 1 S4, 2 S5, 3 CCTL. hi = PHI2 high time in clocks.
  task automatic bus_cycle(input logic [7:0] t, input bit rd, input int win,
                           input logic [12:0] ad, input logic [7:0] dd,
                           input int hi, input bit r500);
    bit          en4, en5;
    logic [31:0] full;
    @(negedge clk_clk);
    quiet = 1'b0;
    n_oe = 0; n_bd = 0;
    seen_addr = 32'hFFFF_FFFF; seen_dout = 32'hFFFF_FFFF;
    en4 = (t == 8'd2) || (t == 8'd3);
    en5 = (t >= 8'd1) && (t <= 8'd4) && !((t == 8'd4) && m_bank[7]);
    exp_hit = rd && (((win == 1) && en4) || ((win == 2) && en5));
    case (t)
      8'd1:    full = 32'(ad);
      8'd2:    full = ((win == 2) ? 32'd8192 : 32'd0) + 32'(ad);
      8'd3:    full = ((win == 2) ? 32'd127 : 32'(m_bank % 128)) * 32'd8192 + 32'(ad);
      8'd4:    full = 32'(m_bank % 16) * 32'd8192 + 32'(ad);
      default: full = 0;
    endcase
    exp_addr  = full[19:0];
    exp_drive = exp_hit && (hi >= 8);
    cart_type = t; rw = rd; a = ad; d_in = dd;
    s4_n = (win != 1); s5_n = (win != 2); cctl_n = (win != 3);
    repeat (3) @(negedge clk_clk);
    phi2 = 1'b1;
    repeat (hi) @(negedge clk_clk);
    if (r500) reset_d500 = 1'b1;
    phi2 = 1'b0;
    repeat (6) @(negedge clk_clk);
    reset_d500 = 1'b0;
    s4_n = 1'b1; s5_n = 1'b1; cctl_n = 1'b1;
    m_type = t;
    if (win == 3) begin
      if ((t == 8'd3) && !rd) m_bank = dd;
      if (t == 8'd4) m_bank = 8'((ad[4] ? 128 : 0) + int'(ad[3:0]));
`ifdef ATARI_D500_CAPTURE_EN
      if (!rd) m_d500 = dd;
`endif
    end
    if (r500) begin m_bank = 8'd0; m_d500 = 8'd0; end
    repeat (2) @(negedge clk_clk);
    quiet = 1'b1;
    repeat (4) @(negedge clk_clk);
    check("drove", 32'(n_oe > 0), 32'(exp_drive));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d_out"}, 32'(d_out), 0);
    check({tag, "_d_oe"}, 32'(d_oe), 0);
    check({tag, "_rd4"}, 32'(rd4), 0);
    check({tag, "_rd5"}, 32'(rd5), 0);
    check({tag, "_sram_addr"}, 32'(sram_addr), 0);
    check({tag, "_sram_enable"}, 32'(sram_enable), 0);
    check({tag, "_bus_driven"}, 32'(bus_driven), 0);
    check({tag, "_d500"}, 32'(d500_byte), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(negedge clk_clk);
    #1 check_all_zero("reset");
    reset_reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);
    cmp_en = 1'b1;

    // Type 1, S5 read of the preloaded byte
    bus_cycle(8'd1, 1'b1, 2, 13'h0123, 8'h00, 10, 1'b0);
    check("t1_addr", seen_addr, 32'h00123);
    check("t1_dout", seen_dout, 32'h5A);
    check("t1_rd5", 32'(rd5), 1);
    check("t1_rd4", 32'(rd4), 0);

    // Type 2, both windows
    bus_cycle(8'd2, 1'b1, 1, 13'h0010, 8'h00, 10, 1'b0);
    check("t2_s4_addr", seen_addr, 32'h00010);
    bus_cycle(8'd2, 1'b1, 2, 13'h0010, 8'h00, 10, 1'b0);
    check("t2_s5_addr", seen_addr, 32'h02010);

    // Type 3, bank write then both windows
    bus_cycle(8'd3, 1'b0, 3, 13'h1D00, 8'h05, 10, 1'b0);
    bus_cycle(8'd3, 1'b1, 1, 13'h0000, 8'h00, 10, 1'b0);
    check("t3_s4_addr", seen_addr, 32'h0A000);
    bus_cycle(8'd3, 1'b1, 2, 13'h0000, 8'h00, 10, 1'b0);
    check("t3_s5_addr", seen_addr, 32'hFE000);

    // Type 4, disable then re-enable
    bus_cycle(8'd4, 1'b0, 3, 13'h0013, 8'h00, 10, 1'b0);
    check("t4_dis_rd5", 32'(rd5), 0);
    bus_cycle(8'd4, 1'b1, 2, 13'h0000, 8'h00, 10, 1'b0);
    check("t4_dis_no_drive", 32'(n_oe + n_bd), 0);
    bus_cycle(8'd4, 1'b1, 3, 13'h0002, 8'h00, 10, 1'b0);
    check("t4_en_rd5", 32'(rd5), 1);
    bus_cycle(8'd4, 1'b1, 2, 13'h0000, 8'h00, 10, 1'b0);
    check("t4_s5_addr", seen_addr, 32'h04000);

    // reset_d500 coincident with a CCTL write: bank stays 0
    bus_cycle(8'd3, 1'b0, 3, 13'h1D00, 8'h33, 10, 1'b1);
    bus_cycle(8'd3, 1'b1, 1, 13'h0000, 8'h00, 10, 1'b0);
    check("d500rst_bank_addr", seen_addr, 32'h00000);

    // Early PHI2 fall during FETCH
    bus_cycle(8'd1, 1'b1, 2, 13'h0123, 8'h00, 3, 1'b0);
    check("early_fall_no_oe", 32'(n_oe), 0);

    // CCTL data capture
    bus_cycle(8'd1, 1'b0, 3, 13'h1D00, 8'hA7, 10, 1'b0);
`ifdef ATARI_D500_CAPTURE_EN
    check("d500_capture", 32'(d500_byte), 32'hA7);
`else
    check("d500_tied", 32'(d500_byte), 32'h00);
`endif

    // Async reset in the middle of a fetch
    @(negedge clk_clk);
    cmp_en = 1'b0; quiet = 1'b0;
    cart_type = 8'd1; rw = 1'b1; s5_n = 1'b0; a = 13'h0055;
    repeat (3) @(negedge clk_clk);
    phi2 = 1'b1;
    for (int i = 0; i < 20 && !bus_driven; i++) @(negedge clk_clk);
    check("reach_fetch", 32'(bus_driven), 1);
    #2 reset_reset_n = 1'b0;
    #1 check_all_zero("midfetch_reset");
    phi2 = 1'b0; s5_n = 1'b1;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    m_bank = 8'd0; m_type = 8'd0; m_d500 = 8'd0;
    repeat (3) @(negedge clk_clk);
    cmp_en = 1'b1;

    // Randomised traffic against the model
    for (int n = 0; n < 200; n++) begin
      logic [7:0] t;
      int         win, hi;
      bit         rd, r500;
      t    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4));
      win  = $urandom_range(0, 3);
      rd   = ($urandom_range(0, 3) != 0);
      hi   = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(8, 14);
      r500 = ($urandom_range(0, 9) == 0);
      bus_cycle(t, rd, win, 13'($urandom), 8'($urandom), hi, r500);
    end

    quiet = 1'b0;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
